lr_train_controller: RTL and testbench
======================================

// Module: lr_train_controller
// PURPOSE
//  Top-level sequencer for the linear-regression training datapath. Walks the sample memory
//  once per epoch, loading each (x,y) pair and pulsing the coefficient-update stage. It then
//  hands off to the error calculator via en_err/err_ready. It reports busy/done to the host.
//  Sits between the host start/done handshake and the data memory, coefficient and error units.
// PARAMETERS
//  N_SAMPLES  150  samples per epoch (>=1); addresses 0..N_SAMPLES-1
//  ADDR_W     8    sample address width; must satisfy 2**ADDR_W >= N_SAMPLES
//  EPOCH_W    4    width of epoch-count input/counter
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        host start; sampled only in IDLE
//  epochs     in   EPOCH_W  training passes; latched on accepted start; 0 treated as 1
//  err_ready  in   1        error calculator idle/ready (high when idle, low while running)
//  addr       out  ADDR_W   sample memory address
//  ld_x       out  1        load x register from memory[addr]
//  ld_y       out  1        load y register from memory[addr]
//  coef_upd   out  1        one-cycle pulse: update b0/b1 with currently loaded sample
//  en_err     out  1        one-cycle pulse: start error calculation pass
//  busy       out  1        high in every state except IDLE
//  done       out  1        one-cycle pulse when training completes
// BEHAVIOUR
//  Reset: state=IDLE; addr=0; epoch_cnt=0; ld_x=ld_y=coef_upd=en_err=busy=done=0.
//  All outputs are decoded from state/counters (Moore); no input-to-output combinational path.
//  The following states use a 3-bit encoding:
//  - IDLE: on start=1: latch epochs (0->1), addr<=0, epoch_cnt<=0 -> LOAD. Otherwise stay.
//  - LOAD: ld_x=ld_y=1 -> UPDATE
//  - UPDATE: coef_upd=1 -> NEXT
//  - NEXT: if addr==N_SAMPLES-1 then addr<=0 and go to end-of-epoch; else addr<=addr+1 -> LOAD
//  - ERR_REQ: en_err=1 -> ERR_WAIT; clears seen_busy flag
//  - ERR_WAIT: set seen_busy when err_ready=0. Leave when seen_busy=1 and err_ready=1.
//    A high err_ready before a low is never taken as completion.
//  - DONE: done=1 for one cycle -> IDLE
//  End-of-epoch (leaving NEXT, or ERR_WAIT): last = (epoch_cnt==epochs_l-1).
//    If last: go via ERR_REQ/ERR_WAIT to DONE. Otherwise epoch_cnt++ and go to LOAD
//    (see CONFIGURATION).
//  Latency: 3 cycles per sample; epoch = 3*N_SAMPLES cycles excluding the error pass.
//  addr wraps only via the explicit reset in NEXT; it never exceeds N_SAMPLES-1.
//  start while busy is ignored. Changing epochs mid-run has no effect.
//  rst mid-operation aborts immediately to reset values; the error unit is not notified.
//  Simultaneous start and rst: rst wins.
// CONFIGURATION
//  LR_ERR_EVERY_EPOCH_EN defined: an error pass (ERR_REQ/ERR_WAIT) runs after every epoch.
//    After ERR_WAIT the flow goes to DONE if last, else increments epoch_cnt and goes to LOAD.
//  Undefined: non-last epochs go from NEXT directly to LOAD (epoch_cnt++).
//    Only the final epoch runs the error pass.
// STRUCTURE
//  Shared package/header lr_defs: state encodings (S_IDLE..S_DONE, 3 bits).
//  Sub-module lr_sample_counter: addr register with clr/inc and terminal-count flag
//  (addr==N_SAMPLES-1). It is parameterised by N_SAMPLES and ADDR_W.
//  FSM, epoch counter and seen_busy flag live in the top module.
// TESTING (bench: N_SAMPLES=4; error-unit model drops err_ready 2 cycles after en_err, 5 cycles)
//  1. rst high, then low, start=0 for 10 cycles -> all outputs 0, busy=0, addr=0 throughout.
//  2. epochs=1, start pulse -> ld_x/ld_y at addr 0,1,2,3, each followed next cycle by coef_upd.
//     Then a single en_err, then done exactly once after err_ready returns high; busy then 0.
//  3. epochs=3, macro undefined -> 12 coef_upd pulses, exactly 1 en_err, 1 done.
//     With the macro defined -> 12 coef_upd pulses, 3 en_err, 1 done.
//  4. epochs=0 -> behaves identically to epochs=1 (4 coef_upd, 1 done).
//  5. err_ready held high for 3 cycles after en_err before dropping -> controller stays in
//     ERR_WAIT; done only after the low-then-high sequence completes.
//  6. rst asserted while addr=2 -> next cycle all outputs 0. A repeated start is ignored while
//     busy, then a restart after reset begins at addr 0.

Source files
------------

// File: rtl/lr_train_controller_pkg.sv
// Shared definitions for the linear-regression training controller:
// the 3-bit sequencer state encoding used by lr_train_controller.
package lr_defs;

  localparam int LR_STATE_W = 3;

  typedef enum logic [LR_STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_UPDATE   = 3'd2,
    S_NEXT     = 3'd3,
    S_ERR_REQ  = 3'd4,
    S_ERR_WAIT = 3'd5,
    S_DONE     = 3'd6
  } lr_state_e;

endpackage

// File: rtl/lr_sample_counter.sv
// Sample-memory address counter with synchronous clear/increment and a
// terminal-count flag raised on the last sample address of an epoch.
module lr_sample_counter #(
  parameter int N_SAMPLES = 150,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  logic [ADDR_W-1:0] addr_r;

  // Address register; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (clr) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (inc) begin
      addr_r <= addr_r + ADDR_W'(1);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr = addr_r;
  assign tc   = (addr_r == LAST_ADDR);

endmodule

// File: rtl/lr_train_controller.sv
// Training sequencer: walks the sample memory once per epoch and hands off to
// the error calculator. Define LR_ERR_EVERY_EPOCH_EN to run an error pass after every epoch.
module lr_train_controller
  import lr_defs::*;
#(
  parameter int N_SAMPLES = 150,
  parameter int ADDR_W    = 8,
  parameter int EPOCH_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [EPOCH_W-1:0] epochs,
  input  logic               err_ready,
  output logic [ADDR_W-1:0]  addr,
  output logic               ld_x,
  output logic               ld_y,
  output logic               coef_upd,
  output logic               en_err,
  output logic               busy,
  output logic               done
);

  lr_state_e          state_r, state_s;
  logic [EPOCH_W-1:0] epochs_l_r, epochs_l_s;
  logic [EPOCH_W-1:0] epoch_cnt_r, epoch_cnt_s;
  logic               seen_busy_r, seen_busy_s;
  logic               cnt_clr_s, cnt_inc_s, tc_s, last_s;
  logic               ld_r, upd_r, en_err_r, busy_r, done_r;

  lr_sample_counter #(
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W)
  ) u_sample_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr_s),
    .inc  (cnt_inc_s),
    .addr (addr),
    .tc   (tc_s)
  );

  assign last_s = (epoch_cnt_r == (epochs_l_r - EPOCH_W'(1)));

  // State, epoch bookkeeping and error-handshake flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      epochs_l_r  <= {EPOCH_W{1'b0}};
      epoch_cnt_r <= {EPOCH_W{1'b0}};
      seen_busy_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      epochs_l_r  <= epochs_l_s;
      epoch_cnt_r <= epoch_cnt_s;
      seen_busy_r <= seen_busy_s;
    end
  end

  // Next-state logic and counter controls.
  always_comb begin
    state_s     = state_r;
    epochs_l_s  = epochs_l_r;
    epoch_cnt_s = epoch_cnt_r;
    seen_busy_s = seen_busy_r;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          epochs_l_s  = (epochs == {EPOCH_W{1'b0}}) ? EPOCH_W'(1) : epochs;
          epoch_cnt_s = {EPOCH_W{1'b0}};
          cnt_clr_s   = 1'b1;
          state_s     = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD:   state_s = S_UPDATE;
      S_UPDATE: state_s = S_NEXT;
      S_NEXT: begin
        if (tc_s) begin
          cnt_clr_s = 1'b1;
          if (last_s) begin
            state_s = S_ERR_REQ;
          end else begin
`ifdef LR_ERR_EVERY_EPOCH_EN
            state_s = S_ERR_REQ;
`else
            epoch_cnt_s = epoch_cnt_r + EPOCH_W'(1);
            state_s     = S_LOAD;
`endif
          end
        end else begin
          cnt_inc_s = 1'b1;
          state_s   = S_LOAD;
        end
      end
      S_ERR_REQ: begin
        seen_busy_s = 1'b0;
        state_s     = S_ERR_WAIT;
      end
      S_ERR_WAIT: begin
        // Only a low-then-high err_ready sequence counts as completion.
        if (!err_ready) begin
          seen_busy_s = 1'b1;
          state_s     = S_ERR_WAIT;
        end else if (seen_busy_r) begin
          if (last_s) begin
            state_s = S_DONE;
          end else begin
            epoch_cnt_s = epoch_cnt_r + EPOCH_W'(1);
            state_s     = S_LOAD;
          end
        end else begin
          state_s = S_ERR_WAIT;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Moore outputs registered from the next state so they align with the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_r     <= 1'b0;
      upd_r    <= 1'b0;
      en_err_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      ld_r     <= (state_s == S_LOAD);
      upd_r    <= (state_s == S_UPDATE);
      en_err_r <= (state_s == S_ERR_REQ);
      busy_r   <= (state_s != S_IDLE);
      done_r   <= (state_s == S_DONE);
    end
  end

  assign ld_x     = ld_r;
  assign ld_y     = ld_r;
  assign coef_upd = upd_r;
  assign en_err   = en_err_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_lr_train_controller.sv
// Self-checking bench for lr_train_controller: randomized runs compared as
// event traces against a trace built from the training rules (N_SAMPLES=4).
module tb_lr_train_controller;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int EW = 4;
  localparam int K_LD = 0, K_UPD = 1, K_EN = 2, K_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [EW-1:0] epochs = '0;
  logic          err_ready = 1'b1;
  logic [AW-1:0] addr;
  logic          ld_x, ld_y, coef_upd, en_err, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int kind;
    int addr;
    int cyc;
    bit seq_ok;
  } ev_t;

  ev_t obs[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  ldy_bad = 0;

  int drop_delay_cfg = 2;
  int low_len_cfg = 5;
  int em_phase = 0;
  int em_cnt = 0;
  bit seq_done = 1'b0;

  always #5 clk = ~clk;

  lr_train_controller #(
    .N_SAMPLES (N),
    .ADDR_W    (AW),
    .EPOCH_W   (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .epochs    (epochs),
    .err_ready (err_ready),
    .addr      (addr),
    .ld_x      (ld_x),
    .ld_y      (ld_y),
    .coef_upd  (coef_upd),
    .en_err    (en_err),
    .busy      (busy),
    .done      (done)
  );

  // Error-unit model: drops err_ready drop_delay_cfg cycles after en_err, low for low_len_cfg.
  always @(negedge clk) begin : err_unit
    if (rst) begin
      em_phase  = 0;
      err_ready = 1'b1;
      seq_done  = 1'b0;
    end else begin
      case (em_phase)
        0: if (en_err) begin
          seq_done = 1'b0;
          em_cnt   = drop_delay_cfg;
          em_phase = 1;
        end
        1: begin
          em_cnt = em_cnt - 1;
          if (em_cnt <= 0) begin
            err_ready = 1'b0;
            em_cnt    = low_len_cfg;
            em_phase  = 2;
          end
        end
        2: begin
          em_cnt = em_cnt - 1;
          if (em_cnt <= 0) begin
            err_ready = 1'b1;
            seq_done  = 1'b1;
            em_phase  = 0;
          end
        end
        default: em_phase = 0;
      endcase
    end
  end

  // Output monitor: turns strobes into a time-stamped event trace.
  always @(negedge clk) begin : mon
    cyc = cyc + 1;
    if (!rst) begin
      if (ld_x != ld_y) ldy_bad = ldy_bad + 1;
      if (ld_x)     obs.push_back('{kind: K_LD,   addr: int'(addr), cyc: cyc, seq_ok: 1'b0});
      if (coef_upd) obs.push_back('{kind: K_UPD,  addr: int'(addr), cyc: cyc, seq_ok: 1'b0});
      if (en_err)   obs.push_back('{kind: K_EN,   addr: int'(addr), cyc: cyc, seq_ok: 1'b0});
      if (done) begin
        obs.push_back('{kind: K_DONE, addr: int'(addr), cyc: cyc, seq_ok: seq_done});
        done_cnt = done_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_training(input string tag, input int ep_in, input bit poke_mid);
    int base, eff, d0, waited, viol, hs_bad, prev_ld, nobs;
    int exp_q[$];
    base = obs.size();
    d0   = done_cnt;
    eff  = (ep_in == 0) ? 1 : ep_in;
    for (int e = 0; e < eff; e++) begin
      for (int a = 0; a < N; a++) begin
        exp_q.push_back(K_LD * 256 + a);
        exp_q.push_back(K_UPD * 256 + a);
      end
`ifdef LR_ERR_EVERY_EPOCH_EN
      exp_q.push_back(K_EN * 256);
`else
      if (e == eff - 1) exp_q.push_back(K_EN * 256);
`endif
    end
    exp_q.push_back(K_DONE * 256);

    @(negedge clk);
    epochs = EW'(ep_in);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    if (poke_mid) begin
      repeat (2 + $urandom_range(0, 4)) @(negedge clk);
      start  = 1'b1;
      epochs = EW'($urandom_range(0, 15));
      @(negedge clk);
      start = 1'b0;
    end
    waited = 0;
    while (done_cnt == d0 && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    check_eq({tag, "_no_timeout"}, {31'd0, waited < 3000}, 32'd1);
    #1;
    check_eq({tag, "_idle_after_done"}, {30'd0, busy, done}, 32'd0);
    repeat (6) @(negedge clk);

    nobs = obs.size() - base;
    check_eq({tag, "_nevents"}, nobs, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < nobs; i++) begin
      check_eq($sformatf("%s_ev%0d", tag, i), obs[base+i].kind * 256 + obs[base+i].addr, exp_q[i]);
    end
    viol = 0;
    hs_bad = 0;
    prev_ld = -100;
    for (int i = base; i < obs.size(); i++) begin
      if (obs[i].kind == K_LD) begin
        if (obs[i].addr != 0 && obs[i].cyc != prev_ld + 3) viol++;
        prev_ld = obs[i].cyc;
      end else if (obs[i].kind == K_UPD) begin
        if (obs[i].cyc != prev_ld + 1) viol++;
      end else if (obs[i].kind == K_DONE) begin
        if (!obs[i].seq_ok) hs_bad++;
      end
    end
    check_eq({tag, "_sample_timing"}, viol, 0);
    check_eq({tag, "_err_handshake"}, hs_bad, 0);
    check_eq({tag, "_ldx_eq_ldy"}, ldy_bad, 0);
  endtask

  initial begin : stim
    int bad, w;
    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    check_eq("in_reset", {25'd0, addr, ld_x, ld_y, coef_upd, en_err, busy, done}, 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ({ld_x, ld_y, coef_upd, en_err, busy, done} != 6'd0 || addr != '0) bad++;
    end
    check_eq("reset_idle", bad, 0);

    // Directed runs.
    run_training("ep1", 1, 1'b0);
    run_training("ep3", 3, 1'b0);
    run_training("ep0", 0, 1'b0);
    drop_delay_cfg = 3;
    run_training("late_drop", 1, 1'b0);
    drop_delay_cfg = 2;

    // Abort mid-epoch with start and rst together, then restart.
    @(negedge clk);
    epochs = EW'(2);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(ld_x && addr == AW'(2)) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_eq("abort_reach_addr2", {31'd0, w < 200}, 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_eq("abort_outputs", {25'd0, addr, ld_x, ld_y, coef_upd, en_err, busy, done}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_wins_idle", {31'd0, busy}, 32'd0);
    run_training("restart_poke", 1, 1'b1);

    // Randomized runs.
    for (int i = 0; i < 8; i++) begin
      drop_delay_cfg = $urandom_range(1, 4);
      low_len_cfg    = $urandom_range(1, 6);
      run_training($sformatf("rnd%0d", i), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
